// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : alu_share_arbiter
// Brief   : Round-robin share of one external combinational ALU between two
//           valid/ready requesters, with a captured, held response per op.
// Revision: 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [N-1:0]     req0_a,
  input  logic [N-1:0]     req0_b,
  input  logic [3:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [N-1:0]     req1_a,
  input  logic [N-1:0]     req1_b,
  input  logic [3:0]       req1_ctrl,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [N-1:0]     rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [N-1:0]     alu_result,
  input  logic [3:0]       alu_flags,
  output logic [CNT_W-1:0] ops_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic             r_rr_last;
  logic             r_owner;
  logic [N-1:0]     r_alu_a;
  logic [N-1:0]     r_alu_b;
  logic [3:0]       r_alu_ctrl;
  logic [N-1:0]     r_rsp_result;
  logic [3:0]       r_rsp_flags;
  logic [CNT_W-1:0] r_ops_done;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_accept;
  logic             w_rsp_take;

  // Only the owner's ready bit can retire a response.
  assign w_accept   = w_gnt0 | w_gnt1;
  assign w_rsp_take = (r_state == S_RESP) && rsp_ready[r_owner];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)   w_next = S_EXEC;
      S_EXEC:                  w_next = S_RESP;
      S_RESP:  if (w_rsp_take) w_next = S_IDLE;
      default:                 w_next = S_IDLE;
    endcase
  end

  // Contended grant goes to the port that was not served last.
  always_comb begin
    w_gnt0    = 1'b0;
    w_gnt1    = 1'b0;
    rsp_valid = 2'b00;
    if (r_state == S_IDLE) begin
      if (req0_valid && req1_valid) begin
        w_gnt0 = r_rr_last;
        w_gnt1 = ~r_rr_last;
      end else begin
        w_gnt0 = req0_valid;
        w_gnt1 = req1_valid;
      end
    end
    if (r_state == S_RESP) begin
      rsp_valid = r_owner ? 2'b10 : 2'b01;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_last    <= 1'b1;
      r_owner      <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_ctrl   <= '0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_ops_done   <= '0;
    end else begin
      if (w_accept) begin
        r_alu_a    <= w_gnt1 ? req1_a    : req0_a;
        r_alu_b    <= w_gnt1 ? req1_b    : req0_b;
        r_alu_ctrl <= w_gnt1 ? req1_ctrl : req0_ctrl;
        r_owner    <= w_gnt1;
        r_rr_last  <= w_gnt1;
      end
      if (r_state == S_EXEC) begin
        r_rsp_result <= alu_result;
        r_rsp_flags  <= alu_flags;
      end
      if (w_rsp_take) begin
        r_ops_done <= r_ops_done + 1'b1;
      end
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_ctrl   = r_alu_ctrl;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;
  assign ops_done   = r_ops_done;

endmodule
`default_nettype wire
